// File: rtl/kw4281_pkg.sv
// +----------------------------------------------------------------------------
// | kw4281_pkg : shared types for the KW4281 display scheduler
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package kw4281_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    NOTICE = 2'd2
  } state_t;

  typedef logic [3:0][3:0] hex4_t;

endpackage

`default_nettype wire

// File: rtl/kw4281_rr_pick.sv
// +----------------------------------------------------------------------------
// | kw4281_rr_pick : next enabled index strictly after cur, wrapping around
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module kw4281_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         en,
  input  logic [$clog2(N)-1:0] cur,
  output logic [$clog2(N)-1:0] nxt,
  output logic                 valid
);

  localparam int c_idx_w = $clog2(N);

  logic [c_idx_w-1:0] w_cand;

  // Scan from the farthest offset down so the nearest enabled index wins;
  // offset N is cur itself, which covers the single-enabled case.
  always_comb begin
    w_cand = '0;
    nxt    = cur;
    for (int k = N; k >= 1; k--) begin
      w_cand = c_idx_w'((int'(cur) + k) % N);
      if (en[w_cand]) begin
        nxt = w_cand;
      end
    end
  end

  assign valid = |en;

endmodule

`default_nettype wire

// File: rtl/kw4281_display_scheduler.sv
// +----------------------------------------------------------------------------
// | kw4281_display_scheduler : rotates enabled sources onto the KW4281 display,
// |                            with a pre-empting timed notice channel
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module kw4281_display_scheduler
  import kw4281_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int DWELL_MS  = 2000,
  parameter int NOTICE_MS = 1000
) (
  input  logic                         clk_1000hz,
  input  logic                         rst_n,
  input  logic [NUM_SRC-1:0][3:0][3:0] src_hex,
  input  logic [NUM_SRC-1:0]           src_en,
  input  logic                         hold,
  input  logic                         notice_req,
  input  hex4_t                        notice_hex,
  output logic                         notice_ack,
  output hex4_t                        disp_hex,
  output logic [$clog2(NUM_SRC)-1:0]   disp_src,
  output logic                         notice_active
);

  localparam int c_ptr_w    = $clog2(NUM_SRC);
  localparam int c_dwell_w  = $clog2(DWELL_MS);
  localparam int c_notice_w = $clog2(NOTICE_MS);

  localparam logic [c_ptr_w-1:0]    c_last_idx    = c_ptr_w'(NUM_SRC - 1);
  localparam logic [c_dwell_w-1:0]  c_dwell_last  = c_dwell_w'(DWELL_MS - 1);
  localparam logic [c_notice_w-1:0] c_notice_last = c_notice_w'(NOTICE_MS - 1);

  state_t                r_state;
  logic [c_ptr_w-1:0]    r_ptr;
  logic [c_dwell_w-1:0]  r_dwell;
  logic [c_notice_w-1:0] r_ncnt;
  hex4_t                 r_latch;

  logic [c_ptr_w-1:0]    w_pick_cur;
  logic [c_ptr_w-1:0]    w_pick_idx;
  logic                  w_pick_valid;
  logic                  w_accept;

  // From IDLE, searching after the last index yields the lowest enabled one.
  assign w_pick_cur = (r_state == IDLE) ? c_last_idx : r_ptr;
  assign w_accept   = notice_req && (r_state != NOTICE);

  kw4281_rr_pick #(
    .N (NUM_SRC)
  ) u_pick (
    .en    (src_en),
    .cur   (w_pick_cur),
    .nxt   (w_pick_idx),
    .valid (w_pick_valid)
  );

  always_ff @(posedge clk_1000hz or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_dwell       <= '0;
      r_ncnt        <= '0;
      r_latch       <= '0;
      notice_ack    <= 1'b0;
      disp_hex      <= '0;
      disp_src      <= '0;
      notice_active <= 1'b0;
    end else begin
      // Outputs follow the current state with one cycle of latency.
      disp_src      <= r_ptr;
      notice_ack    <= w_accept;
      notice_active <= (r_state == NOTICE);
      if (r_state == ROTATE)      disp_hex <= src_hex[r_ptr];
      else if (r_state == NOTICE) disp_hex <= r_latch;
      else                        disp_hex <= '0;

      // A notice beats dwell expiry and source disable; ptr is left as is.
      if (w_accept) begin
        r_latch <= notice_hex;
        r_ncnt  <= '0;
        r_state <= NOTICE;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_pick_valid) begin
              r_state <= ROTATE;
              r_ptr   <= w_pick_idx;
              r_dwell <= '0;
            end
          end
          ROTATE: begin
            if (!w_pick_valid) begin
              r_state <= IDLE;
            end else if (!src_en[r_ptr]) begin
              r_ptr   <= w_pick_idx;
              r_dwell <= '0;
            end else if (!hold) begin
              if (r_dwell == c_dwell_last) begin
                r_ptr   <= w_pick_idx;
                r_dwell <= '0;
              end else begin
                r_dwell <= r_dwell + 1'b1;
              end
            end
          end
          NOTICE: begin
            if (r_ncnt == c_notice_last) begin
              r_state <= w_pick_valid ? ROTATE : IDLE;
              r_dwell <= '0;
            end else begin
              r_ncnt <= r_ncnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_kw4281_display_scheduler.sv
// +----------------------------------------------------------------------------
// | tb_kw4281_display_scheduler : directed self-checking bench
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_kw4281_display_scheduler;

  logic                  clk_1000hz = 1'b0;
  logic                  rst_n;
  logic [3:0][3:0][3:0]  src_hex;
  logic [3:0]            src_en;
  logic                  hold;
  logic                  notice_req;
  logic [3:0][3:0]       notice_hex;
  logic                  notice_ack;
  logic [3:0][3:0]       disp_hex;
  logic [1:0]            disp_src;
  logic                  notice_active;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] vals [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  kw4281_display_scheduler #(
    .NUM_SRC   (4),
    .DWELL_MS  (4),
    .NOTICE_MS (3)
  ) dut (
    .clk_1000hz    (clk_1000hz),
    .rst_n         (rst_n),
    .src_hex       (src_hex),
    .src_en        (src_en),
    .hold          (hold),
    .notice_req    (notice_req),
    .notice_hex    (notice_hex),
    .notice_ack    (notice_ack),
    .disp_hex      (disp_hex),
    .disp_src      (disp_src),
    .notice_active (notice_active)
  );

  always #5 clk_1000hz = ~clk_1000hz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] eh, input int es,
                            input logic ea, input logic eact);
    chk({tag, ".hex"}, 32'(disp_hex), 32'(eh));
    chk({tag, ".src"}, 32'(disp_src), 32'(es));
    chk({tag, ".ack"}, 32'(notice_ack), 32'(ea));
    chk({tag, ".act"}, 32'(notice_active), 32'(eact));
  endtask

  task automatic step_chk(input string tag, input logic [15:0] eh, input int es,
                          input logic ea, input logic eact);
    @(posedge clk_1000hz);
    #1;
    check_outs(tag, eh, es, ea, eact);
  endtask

  task automatic rep(input int n, input string tag, input logic [15:0] eh, input int es,
                     input logic ea, input logic eact);
    for (int i = 0; i < n; i++) step_chk(tag, eh, es, ea, eact);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    src_hex[0] = 16'h1111;
    src_hex[1] = 16'h2222;
    src_hex[2] = 16'h3333;
    src_hex[3] = 16'h4444;
    src_en     = 4'b1111;
    hold       = 1'b0;
    notice_req = 1'b0;
    notice_hex = 16'h0000;
    #12;
    check_outs("reset", 16'h0000, 0, 0, 0);
    #1 rst_n = 1'b1;

    // Rotation through all four sources, one idle->rotate cycle first
    step_chk("t1_idle", 16'h0000, 0, 0, 0);
    for (int s = 0; s < 5; s++) rep(4, "t1_rot", vals[s % 4], s % 4, 0, 0);

    // Notice during idx1, then a full dwell on idx1
    step_chk("t3_pre", 16'h2222, 1, 0, 0);
    notice_req = 1'b1; notice_hex = 16'hBEEF;
    step_chk("t3_ack", 16'h2222, 1, 1, 0);
    notice_req = 1'b0; notice_hex = 16'h1234;
    rep(3, "t3_notice", 16'hBEEF, 1, 0, 1);
    rep(4, "t3_dwell", 16'h2222, 1, 0, 0);
    step_chk("t3_next", 16'h3333, 2, 0, 0);

    // Held request: no ack inside NOTICE, re-accepted after one ROTATE cycle
    notice_req = 1'b1; notice_hex = 16'hCAFE;
    step_chk("t4_ack1", 16'h3333, 2, 1, 0);
    rep(3, "t4_held", 16'hCAFE, 2, 0, 1);
    step_chk("t4_ack2", 16'h3333, 2, 1, 0);
    notice_req = 1'b0;
    rep(3, "t4_notice2", 16'hCAFE, 2, 0, 1);
    rep(3, "t4_dwell", 16'h3333, 2, 0, 0);
    notice_req = 1'b1; notice_hex = 16'hF00D;
    step_chk("t4_expiry_ack", 16'h3333, 2, 1, 0);
    notice_req = 1'b0;
    rep(3, "t4_notice3", 16'hF00D, 2, 0, 1);
    step_chk("t4_ptr_kept", 16'h3333, 2, 0, 0);

    // Hold freezes rotation but not the notice timer
    hold = 1'b1;
    rep(10, "t5_hold", 16'h3333, 2, 0, 0);
    hold = 1'b0;
    rep(3, "t5_resume", 16'h3333, 2, 0, 0);
    step_chk("t5_next", 16'h4444, 3, 0, 0);
    hold = 1'b1; notice_req = 1'b1; notice_hex = 16'h0ACE;
    step_chk("t5_ack", 16'h4444, 3, 1, 0);
    notice_req = 1'b0;
    rep(3, "t5_notice", 16'h0ACE, 3, 0, 1);
    step_chk("t5_end", 16'h4444, 3, 0, 0);
    hold = 1'b0;
    step_chk("t5_run", 16'h4444, 3, 0, 0);

    // Partial enable mask, disable of the current source, then all off
    src_en = 4'b0101;
    step_chk("t2_skip", 16'h4444, 3, 0, 0);
    rep(4, "t2_src0", 16'h1111, 0, 0, 0);
    rep(2, "t2_src2", 16'h3333, 2, 0, 0);
    src_en = 4'b0001;
    step_chk("t2_dis", 16'h3333, 2, 0, 0);
    rep(5, "t2_only0", 16'h1111, 0, 0, 0);
    src_en = 4'b0000;
    step_chk("t2_last", 16'h1111, 0, 0, 0);
    step_chk("t2_idle", 16'h0000, 0, 0, 0);

    // Asynchronous reset in the middle of a notice
    src_en = 4'b1110; notice_hex = 16'hDEAD;
    step_chk("t6_start", 16'h0000, 0, 0, 0);
    notice_req = 1'b1;
    step_chk("t6_ack", 16'h2222, 1, 1, 0);
    step_chk("t6_notice", 16'hDEAD, 1, 0, 1);
    #2 rst_n = 1'b0; notice_req = 1'b0;
    #1 check_outs("t6_async_rst", 16'h0000, 0, 0, 0);
    #2 rst_n = 1'b1;
    step_chk("t6_rel_idle", 16'h0000, 0, 0, 0);
    rep(2, "t6_rel_rot", 16'h2222, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
